// File: rtl/pipe_ctrl_unit.sv
`default_nettype none
// ============================================================================
// pipe_ctrl_unit : stall/flush/forward control with shadow in-flight tracking.
// Optional forwarding enabled by PIPE_CTRL_FORWARD_EN.       Rev 1.0
// ============================================================================
module pipe_ctrl_unit #(
   parameter int  STAGES     = 3,
   parameter int  REG_ADDR_W = 4,
   parameter int  CNT_W      = 16,
   localparam int FWD_W      = $clog2(STAGES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] src1,
   input  logic [REG_ADDR_W-1:0] src2,
   input  logic                  two_src,
   input  logic                  id_wb_en,
   input  logic                  id_mem_r_en,
   input  logic                  id_b,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  mem_ready,
   output logic                  hazard,
   output logic                  freeze_if,
   output logic                  flush_if_reg,
   output logic                  flush_id_reg,
   output logic                  branch_taken,
   output logic [FWD_W-1:0]      fwd_sel_a,
   output logic [FWD_W-1:0]      fwd_sel_b,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   // Entry 1 is the instruction in EXE, entry STAGES the one in WB.
   logic                  r_valid    [1:STAGES];
   logic                  r_wb_en    [1:STAGES];
   logic                  r_mem_r_en [1:STAGES];
   logic                  r_b        [1:STAGES];
   logic [REG_ADDR_W-1:0] r_dest     [1:STAGES];
`ifdef PIPE_CTRL_FORWARD_EN
   logic [REG_ADDR_W-1:0] r_src1;
   logic [REG_ADDR_W-1:0] r_src2;
   logic                  r_two_src;
`endif
   logic [CNT_W-1:0]      r_stall_cnt;
   logic [CNT_W-1:0]      r_flush_cnt;
   logic                  w_hazard;
   logic                  w_branch;
   logic                  w_stall_evt;
   logic                  w_flush_evt;

   function automatic logic f_match(input logic [REG_ADDR_W-1:0] s, input int k);
      return r_valid[k] & r_wb_en[k] & (r_dest[k] == s);
   endfunction

   assign w_branch = r_valid[1] & r_b[1];

   always_comb begin
      w_hazard = 1'b0;
`ifdef PIPE_CTRL_FORWARD_EN
      // Only a load in EXE cannot be forwarded in time.
      w_hazard = r_mem_r_en[1] & (f_match(src1, 1) | (two_src & f_match(src2, 1)));
`else
      // WB is excluded: the register file writes before it is read.
      for (int k = 1; k < STAGES; k++) begin
         if (f_match(src1, k) || (two_src && f_match(src2, k)))
            w_hazard = 1'b1;
      end
`endif
   end

   always_comb begin
      fwd_sel_a = '0;
      fwd_sel_b = '0;
`ifdef PIPE_CTRL_FORWARD_EN
      // Descending scan so the youngest producer wins.
      for (int k = STAGES; k >= 2; k--) begin
         if (f_match(r_src1, k))
            fwd_sel_a = FWD_W'(k);
         if (r_two_src && f_match(r_src2, k))
            fwd_sel_b = FWD_W'(k);
      end
`endif
   end

   assign w_stall_evt  = w_hazard & ~w_branch & mem_ready;
   assign w_flush_evt  = w_branch & mem_ready;

   assign hazard       = w_hazard;
   assign branch_taken = w_branch;
   assign freeze_if    = (w_hazard & ~w_branch) | ~mem_ready;
   assign flush_if_reg = w_flush_evt;
   assign flush_id_reg = w_flush_evt;
   assign stall_cnt    = r_stall_cnt;
   assign flush_cnt    = r_flush_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 1; k <= STAGES; k++) begin
            r_valid[k]    <= 1'b0;
            r_wb_en[k]    <= 1'b0;
            r_mem_r_en[k] <= 1'b0;
            r_b[k]        <= 1'b0;
            r_dest[k]     <= '0;
         end
`ifdef PIPE_CTRL_FORWARD_EN
         r_src1    <= '0;
         r_src2    <= '0;
         r_two_src <= 1'b0;
`endif
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else if (mem_ready) begin
         for (int k = STAGES; k >= 2; k--) begin
            r_valid[k]    <= r_valid[k-1];
            r_wb_en[k]    <= r_wb_en[k-1];
            r_mem_r_en[k] <= r_mem_r_en[k-1];
            r_b[k]        <= r_b[k-1];
            r_dest[k]     <= r_dest[k-1];
         end
         r_valid[1]    <= ~(w_hazard | w_branch);
         r_wb_en[1]    <= id_wb_en;
         r_mem_r_en[1] <= id_mem_r_en;
         r_b[1]        <= id_b;
         r_dest[1]     <= id_dest;
`ifdef PIPE_CTRL_FORWARD_EN
         r_src1    <= src1;
         r_src2    <= src2;
         r_two_src <= two_src;
`endif
         if (w_stall_evt && !(&r_stall_cnt))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush_evt && !(&r_flush_cnt))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire
